// File: rtl/nn_shift_pkg.sv
// Shared types for the neuron multiplier server: FSM state encoding and a width helper.
package nn_shift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_CALC,
    ST_DONE,
    ST_RELEASE
  } st_mult_srv_e;

  // Width of a counter/pointer able to address n values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_mult_server_rr_arbiter.sv
// Round-robin pick: first requesting client at or after ptr, wrapping; one-hot plus index.
module rr_arbiter
  import nn_shift_pkg::*;
#(
  parameter int NumClients = 4,
  localparam int PtrW = clog2_min1(NumClients)
) (
  input  logic [NumClients-1:0] req,
  input  logic [PtrW-1:0]       ptr,
  output logic                  valid,
  output logic [NumClients-1:0] pick_oh,
  output logic [PtrW-1:0]       pick_idx
);

  always_comb begin
    valid    = 1'b0;
    pick_oh  = '0;
    pick_idx = '0;
    for (int i = 0; i < NumClients; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NumClients) j = j - NumClients;
      if (!valid && req[j]) begin
        valid       = 1'b1;
        pick_oh[j]  = 1'b1;
        pick_idx    = PtrW'(j);
      end
    end
  end

endmodule

// File: rtl/shared_mult_server.sv
// Round-robin server sharing one sequential signed shift-add multiplier among NumClients neurons.
// Define SHARED_MULT_FAST_EN for radix-4 (two multiplier bits per cycle, DataWidth must be even).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no owner; pick next requester round-robin
// ST_GRANT   | client owns the multiplier; wait for start (or req drop)
// ST_CALC    | shift-add on operand magnitudes, one step per cycle
// ST_DONE    | done pulse is visible for this cycle
// ST_RELEASE | wait for owner to drop req before freeing the grant
module shared_mult_server
  import nn_shift_pkg::*;
#(
  parameter int NumClients = 4,
  parameter int DataWidth  = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic [NumClients-1:0]            mult_req_i,
  input  logic [NumClients-1:0]            mult_start_i,
  input  logic [NumClients*DataWidth-1:0]  mult_a_i,
  input  logic [NumClients*DataWidth-1:0]  mult_b_i,
  output logic [NumClients-1:0]            mult_grant_o,
  output logic                             mult_busy_o,
  output logic [NumClients-1:0]            mult_done_o,
  output logic [2*DataWidth-1:0]           mult_result_o
);

  localparam int PtrW  = clog2_min1(NumClients);
  localparam int ProdW = 2 * DataWidth;
`ifdef SHARED_MULT_FAST_EN
  localparam int Iters = DataWidth / 2;
`else
  localparam int Iters = DataWidth;
`endif
  localparam int CntW = clog2_min1(Iters);
  localparam logic [CntW-1:0] CntLast = CntW'(Iters - 1);

  st_mult_srv_e         state;
  logic [PtrW-1:0]      rr_ptr;
  logic [PtrW-1:0]      owner;
  logic [CntW-1:0]      cnt;
  logic [DataWidth-1:0] a_mag, b_mag;
  logic                 neg;
  logic                 aborted;
  logic [ProdW-1:0]     acc;

  logic                  arb_valid;
  logic [NumClients-1:0] arb_pick_oh;
  logic [PtrW-1:0]       arb_pick_idx;
  logic [DataWidth-1:0]  a_sel, b_sel, a_mag_nx, b_mag_nx;
  logic [ProdW-1:0]      partial, acc_nx;
  logic                  owner_req;

  rr_arbiter #(.NumClients(NumClients)) u_rr_arbiter (
    .req      (mult_req_i),
    .ptr      (rr_ptr),
    .valid    (arb_valid),
    .pick_oh  (arb_pick_oh),
    .pick_idx (arb_pick_idx)
  );

  always_comb begin
    owner_req = mult_req_i[owner];
    a_sel     = mult_a_i[int'(owner)*DataWidth +: DataWidth];
    b_sel     = mult_b_i[int'(owner)*DataWidth +: DataWidth];
    // Magnitude of the most negative value is 2^(DW-1), which still fits unsigned in DW bits.
    a_mag_nx  = a_sel[DataWidth-1] ? -a_sel : a_sel;
    b_mag_nx  = b_sel[DataWidth-1] ? -b_sel : b_sel;
`ifdef SHARED_MULT_FAST_EN
    partial   = (ProdW'(a_mag) * ProdW'(b_mag[2*int'(cnt) +: 2])) << (2 * int'(cnt));
`else
    partial   = b_mag[cnt] ? (ProdW'(a_mag) << cnt) : '0;
`endif
    acc_nx    = acc + partial;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      cnt           <= '0;
      a_mag         <= '0;
      b_mag         <= '0;
      neg           <= 1'b0;
      aborted       <= 1'b0;
      acc           <= '0;
      mult_grant_o  <= '0;
      mult_busy_o   <= 1'b0;
      mult_done_o   <= '0;
      mult_result_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            mult_grant_o <= arb_pick_oh;
            owner        <= arb_pick_idx;
            rr_ptr       <= (int'(arb_pick_idx) == NumClients - 1) ? '0
                                                                   : PtrW'(int'(arb_pick_idx) + 1);
            state        <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!owner_req) begin
            mult_grant_o <= '0;
            state        <= ST_IDLE;
          end else if (mult_start_i[owner]) begin
            a_mag       <= a_mag_nx;
            b_mag       <= b_mag_nx;
            neg         <= a_sel[DataWidth-1] ^ b_sel[DataWidth-1];
            acc         <= '0;
            cnt         <= '0;
            aborted     <= 1'b0;
            mult_busy_o <= 1'b1;
            state       <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc_nx;
          cnt <= CntW'(int'(cnt) + 1);
          if (!owner_req) aborted <= 1'b1;
          if (cnt == CntLast) begin
            mult_busy_o <= 1'b0;
            // A requester that let go at any point during the multiply gets no result.
            if (aborted || !owner_req) begin
              state <= ST_RELEASE;
            end else begin
              mult_result_o <= neg ? -acc_nx : acc_nx;
              mult_done_o   <= mult_grant_o;
              state         <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          mult_done_o <= '0;
          state       <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!owner_req) begin
            mult_grant_o <= '0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mult_server.sv
// Scoreboard bench for shared_mult_server: stimulus pushes expected products, a monitor checks done pulses.
module tb_shared_mult_server;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef SHARED_MULT_FAST_EN
  localparam int CALC_CYC = DW / 2;
`else
  localparam int CALC_CYC = DW;
`endif

  typedef struct {
    int          client;
    logic [15:0] res;
  } exp_t;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b1;

  logic          req_v   [N];
  logic          start_v [N];
  logic [DW-1:0] a_v     [N];
  logic [DW-1:0] b_v     [N];

  logic [N-1:0]    req, start;
  logic [N*DW-1:0] a_bus, b_bus;
  logic [N-1:0]    mult_grant_o, mult_done_o;
  logic            mult_busy_o;
  logic [2*DW-1:0] mult_result_o;

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          glog[$];
  logic [N-1:0] prev_g = '0;
  logic [15:0] last_res = '0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    req   = '0;
    start = '0;
    a_bus = '0;
    b_bus = '0;
    for (int k = 0; k < N; k++) begin
      req[k]            = req_v[k];
      start[k]          = start_v[k];
      a_bus[k*DW +: DW] = a_v[k];
      b_bus[k*DW +: DW] = b_v[k];
    end
  end

  shared_mult_server #(.NumClients(N), .DataWidth(DW)) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .mult_req_i    (req),
    .mult_start_i  (start),
    .mult_a_i      (a_bus),
    .mult_b_i      (b_bus),
    .mult_grant_o  (mult_grant_o),
    .mult_busy_o   (mult_busy_o),
    .mult_done_o   (mult_done_o),
    .mult_result_o (mult_result_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (reset_ni && mult_done_o != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(mult_done_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_client", 32'(mult_done_o), 32'(1 << mon_e.client));
        chk("result", 32'(mult_result_o), 32'(mon_e.res));
      end
    end
  end

  always @(negedge clk_i) begin
    if (mult_grant_o != '0 && prev_g == '0) begin
      chk("grant_onehot", 32'($onehot(mult_grant_o)), 32'd1);
      for (int k = 0; k < N; k++) if (mult_grant_o[k]) glog.push_back(k);
    end
    prev_g <= mult_grant_o;
  end

  // abort_after < 0: normal operation; otherwise drop req that many cycles into the multiply.
  task automatic client_op(input int k, input logic [7:0] a, input logic [7:0] b,
                           input int abort_after, input bit timing);
    int n;
    int bz;
    logic [15:0] e;
    e = ref_prod(a, b);
    @(negedge clk_i);
    req_v[k] = 1'b1;
    a_v[k]   = a;
    b_v[k]   = b;
    n = 0;
    while (!mult_grant_o[k] && n < 120) begin
      @(negedge clk_i);
      n++;
    end
    if (!mult_grant_o[k]) begin
      chk("grant_timeout", 32'd0, 32'd1);
      req_v[k] = 1'b0;
      return;
    end
    if (timing) chk("grant_latency", 32'(n), 32'd1);
    start_v[k] = 1'b1;
    if (abort_after < 0) exp_q.push_back('{k, e});
    @(negedge clk_i);
    start_v[k] = 1'b0;
    a_v[k]     = ~a;
    b_v[k]     = ~b;
    if (abort_after >= 0) begin
      repeat (abort_after) @(negedge clk_i);
      req_v[k] = 1'b0;
      n = 0;
      while (mult_grant_o[k] && n < 40) begin
        @(negedge clk_i);
        n++;
      end
      chk("abort_grant_released", 32'(mult_grant_o[k]), 32'd0);
      chk("abort_result_kept", 32'(mult_result_o), 32'(last_res));
      return;
    end
    n  = 1;
    bz = mult_busy_o ? 1 : 0;
    while (!mult_done_o[k] && n < 100) begin
      @(negedge clk_i);
      n++;
      if (!mult_done_o[k] && mult_busy_o) bz++;
    end
    if (!mult_done_o[k]) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else if (timing) begin
      chk("done_latency", 32'(n), 32'(CALC_CYC + 1));
      chk("busy_cycles", 32'(bz), 32'(CALC_CYC));
    end
    last_res = e;
    req_v[k] = 1'b0;
    n = 0;
    while (mult_grant_o[k] && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("grant_release", 32'(mult_grant_o[k]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5] = '{0, 2, 1, 2, 0};
    for (int k = 0; k < N; k++) begin
      req_v[k]   = 1'b0;
      start_v[k] = 1'b0;
      a_v[k]     = '0;
      b_v[k]     = '0;
    end
    #1 reset_ni = 1'b0;
    #5;
    chk("reset_grant", 32'(mult_grant_o), 32'd0);
    chk("reset_busy", 32'(mult_busy_o), 32'd0);
    chk("reset_done", 32'(mult_done_o), 32'd0);
    chk("reset_result", 32'(mult_result_o), 32'd0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;

    // Contention: pointer 0 favours client 0; after a client-1 grant the pointer favours 2.
    fork
      client_op(0, 8'd3, 8'd5, -1, 1'b0);
      client_op(2, 8'd4, 8'd4, -1, 1'b0);
    join
    client_op(1, 8'd2, 8'd2, -1, 1'b0);
    fork
      client_op(0, 8'd6, 8'd7, -1, 1'b0);
      client_op(2, 8'hFF, 8'hFF, -1, 1'b0);
    join

    client_op(0, 8'd3,  8'd5,  -1, 1'b1);   // 16'h000F
    client_op(1, 8'hF9, 8'h06, -1, 1'b1);   // 16'hFFD6
    client_op(3, 8'h80, 8'h80, -1, 1'b1);   // 16'h4000
    client_op(2, 8'h00, 8'hFF, -1, 1'b1);   // 16'h0000
    client_op(0, 8'h7F, 8'h80, -1, 1'b1);   // 16'hC080
    chk("vector_last_result", 32'(mult_result_o), 32'h0000C080);

    client_op(1, 8'd10, 8'd10, 2, 1'b0);
    client_op(3, 8'hFE, 8'h05, -1, 1'b1);   // 16'hFFF6
    chk("after_abort_result", 32'(mult_result_o), 32'h0000FFF6);

    // Reset in the third multiply cycle wipes every output asynchronously.
    @(negedge clk_i);
    req_v[0] = 1'b1;
    a_v[0]   = 8'd9;
    b_v[0]   = 8'd9;
    @(negedge clk_i);
    chk("rst_test_grant", 32'(mult_grant_o), 32'd1);
    start_v[0] = 1'b1;
    @(negedge clk_i);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    chk("midrst_grant", 32'(mult_grant_o), 32'd0);
    chk("midrst_busy", 32'(mult_busy_o), 32'd0);
    chk("midrst_done", 32'(mult_done_o), 32'd0);
    chk("midrst_result", 32'(mult_result_o), 32'd0);
    req_v[0] = 1'b0;
    last_res = '0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    client_op(0, 8'd2, 8'd3, -1, 1'b1);     // 16'h0006
    chk("post_reset_result", 32'(mult_result_o), 32'h00000006);

    for (int i = 0; i < 60; i++) begin
      client_op(int'($urandom_range(N - 1, 0)), 8'($urandom), 8'($urandom), -1, 1'b0);
    end

    chk("grant_log_len", 32'(glog.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < glog.size()) chk("grant_order", 32'(glog[i]), 32'(exp_order[i]));
    end
    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
